// File: rtl/shr_seq_if.sv
// rtl/shr_seq_if.sv - handshake and data bundle for the sign-magnitude right shifter
interface shr_seq_if #(
  parameter int N = 8
);
  logic         in_start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] o_out;
  logic         o_busy;
  logic         o_valid;
  logic         o_ERR;
  logic         o_lost;

  modport master (
    output in_start, in_a, in_b,
    input  o_out, o_busy, o_valid, o_ERR, o_lost
  );

  modport slave (
    input  in_start, in_a, in_b,
    output o_out, o_busy, o_valid, o_ERR, o_lost
  );
endinterface

// File: rtl/shr_seq.sv
// rtl/shr_seq.sv - sequential sign-magnitude right shifter, one bit per cycle
module shr_seq #(
  parameter int N = 8
) (
  input  logic     in_clk,
  input  logic     in_rst,
  shr_seq_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [N-2:0] LP_MAX = (N-1)'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N-2:0]  r_mag;
  logic          r_sign;
  logic [CW-1:0] r_cnt;
  logic          r_lost;
  logic          r_err;

  state_t        w_state_n;
  logic [N-2:0]  w_mag_n;
  logic          w_sign_n;
  logic [CW-1:0] w_cnt_n;
  logic          w_lost_n;
  logic          w_err_n;
  logic [N-2:0]  w_shr;
  logic [CW-1:0] w_k;

  // Distances of N-1 or more clear the whole magnitude, so cap the iteration count there.
  assign w_k = (bus.in_b[N-2:0] >= LP_MAX) ? CW'(N - 1) : bus.in_b[CW-1:0];

  assign bus.o_out   = {r_sign, r_mag};
  assign bus.o_busy  = (r_state == S_SHIFT);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_ERR   = r_err;
  assign bus.o_lost  = r_lost;

  // Register the FSM state and the datapath; reset wins over any start.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_lost  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mag   <= w_mag_n;
      r_sign  <= w_sign_n;
      r_cnt   <= w_cnt_n;
      r_lost  <= w_lost_n;
      r_err   <= w_err_n;
    end
  end

  // Next-state and datapath update: capture on start, shift one bit per SHIFT cycle.
  always_comb begin
    w_state_n = r_state;
    w_mag_n   = r_mag;
    w_sign_n  = r_sign;
    w_cnt_n   = r_cnt;
    w_lost_n  = r_lost;
    w_err_n   = r_err;
    w_shr     = r_mag >> 1;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_state_n = S_IDLE;
        end
        if (bus.in_start) begin
          w_lost_n = 1'b0;
          w_err_n  = 1'b0;
          if (bus.in_b[N-1]) begin
            // Negative distance: report the error with a zero result and skip shifting.
            w_err_n   = 1'b1;
            w_mag_n   = '0;
            w_sign_n  = 1'b0;
            w_cnt_n   = '0;
            w_state_n = S_DONE;
          end else begin
            w_mag_n = bus.in_a[N-2:0];
            w_cnt_n = w_k;
            if (w_k == '0) begin
              // Going straight to DONE: a zero magnitude must not keep a negative sign.
              w_sign_n  = bus.in_a[N-1] & (|bus.in_a[N-2:0]);
              w_state_n = S_DONE;
            end else begin
              w_sign_n  = bus.in_a[N-1];
              w_state_n = S_SHIFT;
            end
          end
        end
      end
      S_SHIFT: begin
        w_mag_n  = w_shr;
        w_lost_n = r_lost | r_mag[0];
        w_cnt_n  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_sign_n  = r_sign & (|w_shr);
          w_state_n = S_DONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

endmodule
